// File: rtl/alu_seq_port.sv
// Sequential valid/ready front-end for a structural ripple-carry ALU.
// Optional golden-model self-check is built only when ALU_CHECK_EN is defined.

module ALU #(
    parameter int n = 32
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic [2:0]   f,
    output logic [n-1:0] y,
    output logic         carryout,
    output logic         zero,
    output logic         overflow
);
    logic         sub;
    logic [n-1:0] bb;
    logic [n-1:0] sum;
    logic [n:0]   c;
    logic         v;
    logic         is_arith;

    // SUB and SLT both run the adder as a + ~b + 1
    assign sub      = (f == 3'd1) || (f == 3'd2);
    assign is_arith = (f == 3'd0) || (f == 3'd1);
    assign bb       = sub ? ~b : b;
    assign c[0]     = sub;

    genvar i;
    generate
        for (i = 0; i < n; i++) begin : g_fa
            assign sum[i]   = a[i] ^ bb[i] ^ c[i];
            assign c[i + 1] = (a[i] & bb[i]) | (c[i] & (a[i] ^ bb[i]));
        end
    endgenerate

    assign v = c[n] ^ c[n-1];

    always_comb begin
        y = '0;
        case (f)
            3'd0, 3'd1: y = sum;
            3'd2:       y[0] = sum[n-1] ^ v;
            3'd3:       y = a ^ b;
            3'd4:       y = ~(a & b);
            3'd5:       y = a & b;
            3'd6:       y = ~(a | b);
            default:    y = a | b;
        endcase
    end

    assign carryout = is_arith ? c[n] : 1'b0;
    assign overflow = is_arith ? v : 1'b0;
    assign zero     = (y == '0);
endmodule

module alu_seq_port #(
    parameter int N             = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_a,
    input  logic [N-1:0] req_b,
    input  logic [2:0]   req_cmd,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_result,
    output logic         rsp_carryout,
    output logic         rsp_zero,
    output logic         rsp_overflow,
    output logic         rsp_mismatch,
    output logic [7:0]   err_count
);
    localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]   cmd_q, cmd_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [N-1:0] result_q, result_d;
    logic         carry_q, carry_d, zero_q, zero_d, ovf_q, ovf_d;
    logic         capture;

    logic [N-1:0] alu_y;
    logic         alu_co, alu_z, alu_v;

    ALU #(.n(N)) u_alu (
        .a        (a_q),
        .b        (b_q),
        .f        (cmd_q),
        .y        (alu_y),
        .carryout (alu_co),
        .zero     (alu_z),
        .overflow (alu_v)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req_valid) state_d = S_SETTLE;
            S_SETTLE: if (cnt_q == '0) state_d = S_DONE;
            S_DONE:   if (rsp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_DONE);
    end

    assign capture = (state_q == S_SETTLE) && (cnt_q == '0);

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        cmd_d    = cmd_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        if (state_q == S_IDLE && req_valid) begin
            a_d   = req_a;
            b_d   = req_b;
            cmd_d = req_cmd;
            cnt_d = CNT_INIT;
        end else if (state_q == S_SETTLE && cnt_q != '0) begin
            cnt_d = cnt_q - 8'd1;
        end
        if (capture) begin
            result_d = alu_y;
            carry_d  = alu_co;
            zero_d   = alu_z;
            ovf_d    = alu_v;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q      <= '0;
            b_q      <= '0;
            cmd_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            cmd_q    <= cmd_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign rsp_result   = result_q;
    assign rsp_carryout = carry_q;
    assign rsp_zero     = zero_q;
    assign rsp_overflow = ovf_q;

`ifdef ALU_CHECK_EN
    logic [N-1:0] exp_y;
    logic         mismatch_q, mismatch_d;
    logic [7:0]   err_q, err_d;

    always_comb begin
        exp_y = '0;
        case (cmd_q)
            3'd0:    exp_y = a_q + b_q;
            3'd1:    exp_y = a_q - b_q;
            3'd2:    exp_y[0] = ($signed(a_q) < $signed(b_q));
            3'd3:    exp_y = a_q ^ b_q;
            3'd4:    exp_y = ~(a_q & b_q);
            3'd5:    exp_y = a_q & b_q;
            3'd6:    exp_y = ~(a_q | b_q);
            default: exp_y = a_q | b_q;
        endcase
    end

    always_comb begin
        mismatch_d = mismatch_q;
        err_d      = err_q;
        if (capture) begin
            mismatch_d = (alu_y != exp_y);
            if ((alu_y != exp_y) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mismatch_q <= 1'b0;
            err_q      <= '0;
        end else begin
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
        end
    end

    assign rsp_mismatch = mismatch_q;
    assign err_count    = err_q;
`else
    assign rsp_mismatch = 1'b0;
    assign err_count    = '0;
`endif
endmodule

// File: tb/tb_alu_seq_port.sv
// Randomized self-checking bench for alu_seq_port against an arithmetic reference model.

module tb_alu_seq_port;
    localparam int N      = 32;
    localparam int SETTLE = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [N-1:0] req_a = '0;
    logic [N-1:0] req_b = '0;
    logic [2:0]   req_cmd = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [N-1:0] rsp_result;
    logic         rsp_carryout, rsp_zero, rsp_overflow, rsp_mismatch;
    logic [7:0]   err_count;

    int checks = 0;
    int errors = 0;

    alu_seq_port #(.N(N), .SETTLE_CYCLES(SETTLE)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_cmd      (req_cmd),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_carryout (rsp_carryout),
        .rsp_zero     (rsp_zero),
        .rsp_overflow (rsp_overflow),
        .rsp_mismatch (rsp_mismatch),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    // Expected {result, carryout, zero, overflow} from plain arithmetic
    function automatic logic [N+2:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [2:0] cmd);
        logic [N:0]   wide;
        logic [N-1:0] r;
        logic         co, ov;
        co = 1'b0;
        ov = 1'b0;
        r  = '0;
        case (cmd)
            3'd0: begin
                wide = {1'b0, a} + {1'b0, b};
                r    = wide[N-1:0];
                co   = wide[N];
                ov   = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
            end
            3'd1: begin
                r  = a - b;
                co = (a >= b);
                ov = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
            end
            3'd2: r[0] = ($signed(a) < $signed(b));
            3'd3: r = a ^ b;
            3'd4: r = ~(a & b);
            3'd5: r = a & b;
            3'd6: r = ~(a | b);
            default: r = a | b;
        endcase
        return {r, co, (r == '0), ov};
    endfunction

    // Issue one request and wait for rsp_valid; lat counts edges from accept to response
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] cmd,
                         output int lat);
        int w;
        @(negedge clk);
        req_a     = a;
        req_b     = b;
        req_cmd   = cmd;
        req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        req_cmd   = 3'($urandom);
        lat = 0;
        while (!rsp_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic rsp_handshake();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [N+12:0] got, exp;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        got = {req_ready, rsp_valid, rsp_result, rsp_carryout, rsp_zero, rsp_overflow,
               rsp_mismatch, err_count};
        exp = {1'b1, 1'b0, {N{1'b0}}, 3'b000, 1'b0, 8'd0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", got, exp);
        end
    endtask

    task automatic run_checked(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic [2:0] cmd);
        int lat;
        logic [N+19:0] got, exp;
        do_op(a, b, cmd, lat);
        got = {8'(lat), rsp_valid, req_ready, rsp_result, rsp_carryout, rsp_zero, rsp_overflow,
               rsp_mismatch, err_count};
        exp = {8'(SETTLE), 1'b1, 1'b0, model(a, b, cmd), 1'b0, 8'd0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s a=%h b=%h cmd=%0d: got %h expected %h", name, a, b, cmd, got, exp);
        end
        rsp_handshake();
    endtask

    task automatic test_directed();
        run_checked("add_11_10", 32'd11, 32'd10, 3'd0);
        run_checked("sub_2_10", 32'd2, 32'd10, 3'd1);
        run_checked("sub_15_15", 32'd15, 32'd15, 3'd1);
        run_checked("slt_m6_m3", -32'sd6, -32'sd3, 3'd2);
        run_checked("slt_7_2", 32'd7, 32'd2, 3'd2);
        run_checked("slt_m1_m1", '1, '1, 3'd2);
        // Hand-derived values independent of the model
        checks++;
        run_checked("sub_neg8_again", 32'd2, 32'd10, 3'd1);
        if (rsp_result !== 32'hFFFF_FFF8 || rsp_zero !== 1'b0) begin
            errors++;
            $display("FAIL sub_2_10_literal: got %h z=%b expected fffffff8 z=0", rsp_result, rsp_zero);
        end
    endtask

    task automatic test_corners();
        logic [N-1:0] av[4];
        logic [N-1:0] bv[4];
        av = '{'1, '0, '1, '0};
        bv = '{'0, '1, '1, '0};
        for (int c = 0; c < 8; c++)
            for (int p = 0; p < 4; p++)
                run_checked("corner", av[p], bv[p], 3'(c));
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++)
            run_checked("random", $urandom, $urandom, 3'($urandom_range(0, 7)));
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        logic [N+5:0] held;
        logic [N+2:0] exp;
        do_op(32'h1234_5678, 32'h0F0F_0F0F, 3'd3, lat);
        exp = model(32'h1234_5678, 32'h0F0F_0F0F, 3'd3);
        held = {rsp_valid, req_ready, rsp_result, rsp_carryout, rsp_zero, rsp_overflow, 1'b0};
        checks++;
        if ({rsp_result, rsp_carryout, rsp_zero, rsp_overflow} !== exp || lat != SETTLE) begin
            errors++;
            $display("FAIL bp_first: got %h lat=%0d expected %h lat=%0d",
                     {rsp_result, rsp_carryout, rsp_zero, rsp_overflow}, lat, exp, SETTLE);
        end
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_a     = $urandom;
            req_b     = $urandom;
            req_cmd   = 3'($urandom);
            @(negedge clk);
            if ({rsp_valid, req_ready, rsp_result, rsp_carryout, rsp_zero, rsp_overflow, 1'b0} !== held)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
        end
        @(negedge clk);
        req_a     = 32'd100;
        req_b     = 32'd23;
        req_cmd   = 3'd0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release: got valid/ready %b expected 01", {rsp_valid, req_ready});
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_accept: got req_ready %b expected 0", req_ready);
        end
        lat = 0;
        while (!rsp_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (rsp_result !== 32'd123 || lat != SETTLE) begin
            errors++;
            $display("FAIL bp_second_result: got %0d lat=%0d expected 123 lat=%0d",
                     rsp_result, lat, SETTLE);
        end
        rsp_handshake();
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        req_a     = 32'd5;
        req_b     = 32'd6;
        req_cmd   = 3'd0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, req_ready, rsp_result, err_count} !== {1'b0, 1'b1, {N{1'b0}}, 8'd0}) begin
            errors++;
            $display("FAIL reset_mid_state: got v=%b r=%b res=%h err=%0d expected v=0 r=1 res=0 err=0",
                     rsp_valid, req_ready, rsp_result, err_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_discard: got %0d bad cycles expected 0", seen);
        end
        run_checked("xor_after_reset", '1, '0, 3'd3);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_corners();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
